btn_move_encoder: RTL and testbench

//   Front end of the move-request interface into the 2048 game controller.

---
 rtl/game_pkg.sv | 28 ++
 rtl/btn_debounce.sv | 42 ++++
 rtl/btn_move_encoder.sv | 77 +++++++
 tb/tb_btn_move_encoder.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared 2048 game definitions: move directions and
// move-request FSM encoding.
package game_pkg;

  localparam logic [1:0] DIR_LEFT  = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_UP    = 2'b10;
  localparam logic [1:0] DIR_DOWN  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PEND    = 2'd1,
    ST_RELEASE = 2'd2
  } move_state_t;

  // press vector is {D,U,R,L}; left wins
  function automatic logic [1:0] pri_dir(
    input logic [3:0] press
  );
    logic [1:0] d;
    d = DIR_DOWN;
    if (press[0])      d = DIR_LEFT;
    else if (press[1]) d = DIR_RIGHT;
    else if (press[2]) d = DIR_UP;
    return d;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One pushbutton: 2-flop synchroniser, stability counter,
// debounced level and a registered rising-edge pulse.
module btn_debounce
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input  logic clk,
  input  logic clr,
  input  logic btn,
  output logic level,
  output logic rise
);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;
  logic             prev;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
      prev  <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sync <= {sync[0], btn};
      prev <= level;
      rise <= level & ~prev;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/btn_move_encoder.sv
// Turns debounced button presses into single move commands
// on a valid/ready handshake toward the game logic.
module btn_move_encoder
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       btnL,
  input  logic       btnR,
  input  logic       btnU,
  input  logic       btnD,
  input  logic       move_ready,
  output logic       move_valid,
  output logic [1:0] move_dir,
  output logic [3:0] btn_level
);

  logic [3:0]  raw;
  logic [3:0]  rise;
  logic [3:0]  level;
  move_state_t state, state_nxt;
  logic [1:0]  dir_q, dir_nxt;

  assign raw = {btnD, btnU, btnR, btnL};

  for (genvar i = 0; i < 4; i++) begin : g_db
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .clk  (clk),
      .clr  (clr),
      .btn  (raw[i]),
      .level(level[i]),
      .rise (rise[i])
    );
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= ST_IDLE;
      dir_q <= DIR_LEFT;
    end else begin
      state <= state_nxt;
      dir_q <= dir_nxt;
    end
  end

  // presses outside IDLE are dropped on purpose
  always_comb begin
    state_nxt = state;
    dir_nxt   = dir_q;
    unique case (state)
      ST_IDLE: begin
        if (|rise) begin
          state_nxt = ST_PEND;
          dir_nxt   = pri_dir(rise);
        end
      end
      ST_PEND: begin
        if (move_ready) state_nxt = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (level == 4'b0000) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign move_valid = (state == ST_PEND);
  assign move_dir   = dir_q;
  assign btn_level  = level;

endmodule

// File: tb/tb_btn_move_encoder.sv
// Directed bench for btn_move_encoder with DEBOUNCE_CYCLES=4;
// handshakes are scored against a queue of expected directions.
module tb_btn_move_encoder;

  logic       clk = 1'b0;
  logic       clr;
  logic       btnL, btnR, btnU, btnD;
  logic       move_ready;
  logic       move_valid;
  logic [1:0] move_dir;
  logic [3:0] btn_level;

  int tests = 0;
  int fails = 0;
  logic [1:0] sb[$];

  btn_move_encoder #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .btnL      (btnL),
    .btnR      (btnR),
    .btnU      (btnU),
    .btnD      (btnD),
    .move_ready(move_ready),
    .move_valid(move_valid),
    .move_dir  (move_dir),
    .btn_level (btn_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [3:0] obs,
                     input logic [3:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // scoreboard: every accepted handshake must match a queued move
  always @(negedge clk) begin
    if (!clr && move_valid && move_ready) begin
      logic [1:0] e;
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $error("FAIL extra_move observed=%0h expected=none", move_dir);
      end else begin
        e = sb.pop_front();
        assert (move_dir === e) else begin
          fails++;
          $error("FAIL move_dir observed=%0h expected=%0h", move_dir, e);
        end
      end
    end
  end

  initial begin
    clr = 1'b1;
    btnL = 0; btnR = 0; btnU = 0; btnD = 0;
    move_ready = 1'b0;
    #3;
    chk("rst_valid", {3'b0, move_valid}, 4'h0);
    chk("rst_dir", {2'b0, move_dir}, 4'h0);
    chk("rst_level", btn_level, 4'h0);
    tick(2);
    clr = 1'b0;
    tick(2);

    // latency: 7 edges after first sampling edge
    btnL = 1;
    tick(7);
    chk("lat_before", {3'b0, move_valid}, 4'h0);
    tick(1);
    chk("lat_valid", {3'b0, move_valid}, 4'h1);
    chk("lat_dir", {2'b0, move_dir}, 4'h0);
    sb.push_back(2'b00);
    move_ready = 1'b1;
    tick(1);
    chk("lat_drop", {3'b0, move_valid}, 4'h0);
    tick(20);
    chk("hold_norpt", {3'b0, move_valid}, 4'h0);
    btnL = 0;
    tick(10);
    chk("l_rel_level", btn_level, 4'h0);

    // short glitch filtered
    btnU = 1;
    tick(3);
    btnU = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      chk("glitch_level", btn_level, 4'h0);
    end
    chk("glitch_valid", {3'b0, move_valid}, 4'h0);

    // simultaneous R+D -> right only
    sb.push_back(2'b01);
    btnR = 1; btnD = 1;
    tick(12);
    chk("rd_level", btn_level, 4'b1010);
    btnR = 0; btnD = 0;
    tick(10);
    chk("rd_rel", btn_level, 4'h0);
    chk("rd_sb", 4'(sb.size()), 4'h0);
    sb.push_back(2'b11);
    btnD = 1;
    tick(10);
    btnD = 0;
    tick(10);
    chk("d_sb", 4'(sb.size()), 4'h0);

    // stalled handshake, extra press dropped
    move_ready = 1'b0;
    btnU = 1;
    tick(8);
    for (int i = 0; i < 20; i++) begin
      chk("stall_valid", {3'b0, move_valid}, 4'h1);
      chk("stall_dir", {2'b0, move_dir}, 4'h2);
      if (i == 5) btnL = 1;
      tick(1);
    end
    sb.push_back(2'b10);
    move_ready = 1'b1;
    tick(1);
    chk("stall_drop", {3'b0, move_valid}, 4'h0);
    tick(15);
    btnU = 0; btnL = 0;
    tick(12);
    chk("stall_rel", btn_level, 4'h0);
    chk("stall_sb", 4'(sb.size()), 4'h0);

    // async reset mid-handshake
    move_ready = 1'b0;
    btnD = 1;
    tick(8);
    chk("clr_pre", {3'b0, move_valid}, 4'h1);
    #2;
    clr = 1'b1;
    #1;
    chk("clr_valid", {3'b0, move_valid}, 4'h0);
    chk("clr_level", btn_level, 4'h0);
    @(posedge clk);
    #1;
    clr = 1'b0;
    tick(7);
    chk("clr_lat0", {3'b0, move_valid}, 4'h0);
    tick(1);
    chk("clr_lat1", {3'b0, move_valid}, 4'h1);
    chk("clr_dir", {2'b0, move_dir}, 4'h3);
    sb.push_back(2'b11);
    move_ready = 1'b1;
    tick(1);
    chk("clr_drop", {3'b0, move_valid}, 4'h0);
    btnD = 0;
    tick(10);

    // bouncing left
    sb.push_back(2'b00);
    for (int i = 0; i < 10; i++) begin
      btnL = ((i / 2) % 2 == 0);
      tick(1);
    end
    btnL = 1;
    tick(15);
    chk("bounce_level", btn_level, 4'h1);
    btnL = 0;
    tick(10);
    chk("bounce_sb", 4'(sb.size()), 4'h0);
    chk("end_valid", {3'b0, move_valid}, 4'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
